// File: rtl/stopwatch_digit_sequencer.sv
// MM:SS stopwatch digit sequencer: one shared BCD add/sub step rippled across
// the four digits, one digit per clock, arbitrating timebase ticks and buttons.
module stopwatch_digit_sequencer #(
  parameter int ADJ_STEP  = 2,
  parameter int SEC_T_MAX = 5,
  parameter int MIN_T_MAX = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       tick_i,
  input  logic       add_i,
  input  logic       sub_i,
  input  logic       clear_i,
  output logic [3:0] sec_u_o,
  output logic [3:0] sec_t_o,
  output logic [3:0] min_u_o,
  output logic [3:0] min_t_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       wrap_o,
  output logic       lost_o
);

  localparam logic [3:0] STEP   = 4'(ADJ_STEP);
  localparam logic [4:0] UNIT_L = 5'd9;
  localparam logic [4:0] SEC_L  = 5'(SEC_T_MAX);
  localparam logic [4:0] MIN_L  = 5'(MIN_T_MAX);

  typedef enum logic [2:0] {IDLE, D0, D1, D2, D3} state_t;

  state_t     state, nxt;
  logic       op_dec;
  logic [3:0] k;
  logic       tick_p, add_p, sub_p;

  logic [3:0] cur;
  logic [4:0] lim;
  logic [4:0] sum;
  logic       cy;
  logic [3:0] digit_new;

  logic sel_tick, sel_add, sel_sub, cancel;
  logic tick_req, tick_keep, add_keep, sub_keep, lost_n;

  // Digit currently being stepped and its wrap limit
  always_comb begin
    cur = sec_u_o;
    lim = UNIT_L;
    nxt = IDLE;
    case (state)
      D0: begin cur = sec_u_o; lim = UNIT_L; nxt = D1; end
      D1: begin cur = sec_t_o; lim = SEC_L;  nxt = D2; end
      D2: begin cur = min_u_o; lim = UNIT_L; nxt = D3; end
      D3: begin cur = min_t_o; lim = MIN_L;  nxt = IDLE; end
      default: ;
    endcase
  end

  // Shared BCD step; 5-bit intermediates so d+k never overflows before the compare
  always_comb begin
    sum = {1'b0, cur} + {1'b0, k};
    if (!op_dec) begin
      cy        = sum > lim;
      digit_new = 4'(cy ? sum - (lim + 5'd1) : sum);
    end else begin
      cy        = cur < k;
      digit_new = 4'(cy ? {1'b0, cur} + lim + 5'd1 - {1'b0, k}
                        : {1'b0, cur} - {1'b0, k});
    end
  end

  // Arbitration on registered flags; opposing adjust requests cancel
  always_comb begin
    sel_tick = 1'b0;
    sel_add  = 1'b0;
    sel_sub  = 1'b0;
    cancel   = 1'b0;
    if (state == IDLE) begin
      if (add_p && sub_p) cancel   = 1'b1;
      else if (tick_p)    sel_tick = 1'b1;
      else if (add_p)     sel_add  = 1'b1;
      else if (sub_p)     sel_sub  = 1'b1;
    end
  end

  // A request only counts as lost if its flag survives this edge unconsumed
  assign tick_req  = tick_i & run_i;
  assign tick_keep = tick_p & ~sel_tick;
  assign add_keep  = add_p & ~(sel_add | cancel);
  assign sub_keep  = sub_p & ~(sel_sub | cancel);
  assign lost_n    = (tick_req & tick_keep) | (add_i & add_keep) | (sub_i & sub_keep);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_dec  <= 1'b0;
      k       <= 4'd0;
      tick_p  <= 1'b0;
      add_p   <= 1'b0;
      sub_p   <= 1'b0;
      sec_u_o <= 4'd0;
      sec_t_o <= 4'd0;
      min_u_o <= 4'd0;
      min_t_o <= 4'd0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      wrap_o  <= 1'b0;
      lost_o  <= 1'b0;
    end else if (clear_i) begin
      state   <= IDLE;
      tick_p  <= 1'b0;
      add_p   <= 1'b0;
      sub_p   <= 1'b0;
      sec_u_o <= 4'd0;
      sec_t_o <= 4'd0;
      min_u_o <= 4'd0;
      min_t_o <= 4'd0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      wrap_o  <= 1'b0;
      lost_o  <= 1'b0;
    end else begin
      tick_p <= tick_keep | tick_req;
      add_p  <= add_keep | add_i;
      sub_p  <= sub_keep | sub_i;
      lost_o <= lost_n;
      done_o <= 1'b0;
      wrap_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_tick || sel_add || sel_sub) begin
            op_dec <= sel_sub;
            k      <= sel_tick ? 4'd1 : STEP;
            state  <= D0;
            busy_o <= 1'b1;
          end
        end
        default: begin
          case (state)
            D0:      sec_u_o <= digit_new;
            D1:      sec_t_o <= digit_new;
            D2:      min_u_o <= digit_new;
            D3:      min_t_o <= digit_new;
            default: ;
          endcase
          k <= 4'd1;
          if (cy && state != D3) begin
            state <= nxt;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            wrap_o <= cy;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_digit_sequencer.sv
// Directed bench for stopwatch_digit_sequencer with hand-computed expectations.
module tb_stopwatch_digit_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0, tick = 1'b0, add = 1'b0, sub = 1'b0, clr = 1'b0;
  logic [3:0] su, st, mu, mt;
  logic       busy, done, wrap, lost;

  int checks = 0, errors = 0;
  int busy_n = 0, done_n = 0, wrap_n = 0, lost_n = 0, wrap_solo = 0;
  int b0, d0, w0, l0;

  always #5 clk = ~clk;

  stopwatch_digit_sequencer #(.ADJ_STEP(2), .SEC_T_MAX(5), .MIN_T_MAX(5)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run), .tick_i(tick), .add_i(add),
    .sub_i(sub), .clear_i(clr), .sec_u_o(su), .sec_t_o(st), .min_u_o(mu),
    .min_t_o(mt), .busy_o(busy), .done_o(done), .wrap_o(wrap), .lost_o(lost)
  );

  // Pulse/level counters, sampled just after each active edge
  always @(posedge clk) begin
    #1;
    busy_n    <= busy_n + int'(busy);
    done_n    <= done_n + int'(done);
    wrap_n    <= wrap_n + int'(wrap);
    lost_n    <= lost_n + int'(lost);
    wrap_solo <= wrap_solo + int'(wrap & ~done);
  end

  function automatic int tm();
    return int'({mt, mu, st, su});
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b0 = busy_n; d0 = done_n; w0 = wrap_n; l0 = lost_n;
  endtask

  task automatic do_clear();
    clr = 1'b1; cyc(1); clr = 1'b0; cyc(2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(6);
    end
  endtask

  task automatic adds(input int n);
    for (int i = 0; i < n; i++) begin
      add = 1'b1; cyc(1); add = 1'b0; cyc(8);
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_time", tm(), 'h0000);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_lost", int'(lost), 0);
    rst_n = 1'b1;
    cyc(2);

    // Reach 09:59 with 599 ticks
    run = 1'b1;
    ticks(599);
    chk("setup_0959", tm(), 'h0959);

    // Full ripple 09:59 -> 10:00
    snap();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    chk("rip_d0_busy", int'(busy), 1);
    chk("rip_d0_time", tm(), 'h0959);
    cyc(6);
    chk("rip_time", tm(), 'h1000);
    chk("rip_busy_cyc", busy_n - b0, 4);
    chk("rip_done", done_n - d0, 1);
    chk("rip_wrap", wrap_n - w0, 0);

    // Non-rippling tick: sec_u written 3 edges after the request
    snap();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    chk("lat_busy", int'(busy), 1);
    cyc(1);
    chk("lat_time", tm(), 'h1001);
    chk("lat_done", int'(done), 1);
    chk("lat_busy_off", int'(busy), 0);
    cyc(4);
    chk("lat_busy_cyc", busy_n - b0, 1);

    // Wrap both ways
    do_clear();
    chk("clr_time", tm(), 'h0000);
    snap();
    sub = 1'b1; cyc(1); sub = 1'b0; cyc(8);
    chk("sub0_time", tm(), 'h5958);
    chk("sub0_wrap", wrap_n - w0, 1);
    snap();
    add = 1'b1; cyc(1); add = 1'b0; cyc(8);
    chk("addw_time", tm(), 'h0000);
    chk("addw_wrap", wrap_n - w0, 1);
    chk("addw_done", done_n - d0, 1);
    snap();
    sub = 1'b1; cyc(1); sub = 1'b0; cyc(8);
    chk("subw_time", tm(), 'h5958);
    chk("subw_wrap", wrap_n - w0, 1);

    // Arbitration: add/sub cancel, tick runs
    do_clear();
    adds(5);
    chk("arb_setup", tm(), 'h0010);
    snap();
    tick = 1'b1; add = 1'b1; sub = 1'b1; cyc(1);
    tick = 1'b0; add = 1'b0; sub = 1'b0; cyc(10);
    chk("arb_time", tm(), 'h0011);
    chk("arb_done", done_n - d0, 1);

    // Tick ignored while not running
    run = 1'b0;
    snap();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(8);
    chk("norun_time", tm(), 'h0011);
    chk("norun_done", done_n - d0, 0);
    run = 1'b1;

    // Merge: two adds during a 4-digit borrow ripple
    do_clear();
    snap();
    sub = 1'b1; cyc(1); sub = 1'b0; cyc(1);
    chk("mrg_busy", int'(busy), 1);
    add = 1'b1; cyc(1); add = 1'b0; cyc(1);
    add = 1'b1; cyc(1); add = 1'b0; cyc(12);
    chk("mrg_time", tm(), 'h0000);
    chk("mrg_lost", lost_n - l0, 1);
    chk("mrg_done", done_n - d0, 2);
    chk("mrg_wrap", wrap_n - w0, 2);

    // Clear during D2 of 09:59+1, with an add pending
    do_clear();
    ticks(599);
    chk("clr_setup", tm(), 'h0959);
    snap();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    add = 1'b1; cyc(1); add = 1'b0; cyc(1);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clrm_time", tm(), 'h0000);
    chk("clrm_busy", int'(busy), 0);
    cyc(10);
    chk("clrm_time2", tm(), 'h0000);
    chk("clrm_done", done_n - d0, 0);
    chk("clrm_wrap", wrap_n - w0, 0);
    chk("clrm_busy_cyc", busy_n - b0, 3);

    // Async reset mid-ripple
    snap();
    sub = 1'b1; cyc(1); sub = 1'b0; cyc(2);
    chk("rstm_part", tm(), 'h0008);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_time", tm(), 'h0000);
    chk("rstm_busy", int'(busy), 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(10);
    chk("rstm_time2", tm(), 'h0000);
    chk("rstm_done", done_n - d0, 0);

    chk("wrap_solo", wrap_solo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_digit_sequencer.md
# stopwatch_digit_sequencer

Sequences a single shared BCD digit add/subtract step across the four stopwatch digits (MM:SS). It arbitrates between the timebase tick and the user add/sub adjust buttons. Carry and borrow ripple digit by digit, one digit per clock, from seconds-units upward. The block sits between the button/timebase front end and the seven-segment display driver, and is the sole owner of the time registers.

## Interface
Parameters:
- ADJ_STEP, 2, amount added to or subtracted from seconds-units on an add/sub request; legal range 1..9
- SEC_T_MAX, 5, maximum value of the seconds-tens digit
- MIN_T_MAX, 5, maximum value of the minutes-tens digit

Ports:
- clk  in  1  single clock for the whole block
- rst_n  in  1  asynchronous active-low reset
- run_i  in  1  level; when high, tick_i is accepted; when low, tick_i is ignored
- tick_i  in  1  one-cycle pulse from the timebase; requests +1 on seconds-units
- add_i  in  1  one-cycle pulse (debounced button); requests +ADJ_STEP
- sub_i  in  1  one-cycle pulse (debounced button); requests −ADJ_STEP
- clear_i  in  1  one-cycle pulse; synchronous clear to 00:00
- sec_u_o  out  4  seconds units, 0..9
- sec_t_o  out  4  seconds tens, 0..SEC_T_MAX
- min_u_o  out  4  minutes units, 0..9
- min_t_o  out  4  minutes tens, 0..MIN_T_MAX
- busy_o  out  1  high while an operation is in D0..D3
- done_o  out  1  one-cycle pulse after the final digit of an operation is written
- wrap_o  out  1  one-cycle pulse, concurrent with done_o, when the operation carried or borrowed out of min_t
- lost_o  out  1  one-cycle pulse when an incoming request merges into an already-pending request of the same kind

## Operation
- **Reset values:** all digits 0; state IDLE; all pending flags 0; busy_o, done_o, wrap_o and lost_o all 0.
- **Pending flags:** tick_p, add_p and sub_p.
  - Each flag is set at the edge where its input is high. tick_i only sets tick_p when run_i is high.
  - If an input arrives while its flag is already set, the request is merged and lost_o pulses on the next cycle.
- **Arbitration in IDLE**, evaluated on the registered flags:
  - If add_p and sub_p are both set, both are cleared and no operation runs; they cancel.
  - Otherwise the priority is tick_p > add_p > sub_p.
  - The selected flag is cleared. The FSM latches op (INC or DEC) and step (1 for tick, ADJ_STEP for add/sub), then moves to D0.
- **FSM states:** IDLE, D0 (sec_u), D1 (sec_t), D2 (min_u), D3 (min_t).
  - Each Dn state updates its digit at the exit edge.
  - If the digit produced no carry or borrow, the next state is IDLE.
  - Otherwise the FSM advances to Dn+1 with an operand of 1.
  - From D3 the next state is always IDLE.
- **Digit rule** (L = 9 for units digits, L = *_T_MAX for tens digits; k = operand):
  - INC: s = d + k. If s > L, write s − (L+1) and raise carry. Otherwise write s.
  - DEC: if d < k, write d + (L+1) − k and raise borrow. Otherwise write d − k.
  - Intermediate arithmetic is 5 bits wide; stored digits are 4 bits wide.
- **Wrap:** a carry or borrow out of D3 sets wrap_o.
  - INC wraps 59:59 to 00:00.
  - DEC wraps 00:00 to 59:59, with the lower digits filled per the digit rule.
- **clear_i** has the highest priority. At the edge where it is sampled:
  - all digits go to 0 and all pending flags are cleared;
  - any operation in progress is aborted and the FSM goes to IDLE;
  - done_o and wrap_o are not asserted.
- New requests arriving while busy_o is high are latched into the pending flags and serviced in order after the FSM returns to IDLE.
- Asserting rst_n low at any time, including mid-ripple, forces the reset values immediately.

## Timing
- **Edge numbering:** request pulse high in cycle 0 → pending flag set at edge 1 → IDLE selects it at edge 2 (the FSM enters D0) → sec_u updated at edge 3.
- **Latency:** an operation that does not ripple has sec_u updated 3 edges after the request. Each additional rippled digit adds 1 edge; the worst case is D0..D3, i.e. 6 edges.
- **busy_o** is high exactly in the D0..D3 cycles.
- **done_o and wrap_o** are registered and high in the single cycle after the last digit write; the FSM is already back in IDLE during that cycle.
- **Back-to-back operations:** a pending request is selected at the edge after returning to IDLE, so consecutive operations are separated by 1 IDLE cycle.
- **Outputs** are registered with no combinational path from any input to any output.

## Test plan
- **Reset:** hold rst_n low mid-operation, then release → all digits 0, busy_o 0, done_o 0, no spurious done_o after release.
- **Tick ripple:** start at 09:59, run_i=1, one tick_i → digits become 10:00 after 4 digit states; busy_o high 4 cycles; done_o 1 pulse; wrap_o 0.
- **Wrap:**
  - Start at 59:58, one add_i (ADJ_STEP=2) → 00:00, wrap_o=1 together with done_o.
  - Then one sub_i → 59:58, wrap_o=1.
- **Arbitration:**
  - tick_i, add_i and sub_i pulsed in the same cycle from 00:10 → add/sub cancel, tick runs → 00:11, one done_o.
  - tick_i with run_i=0 → no change, no done_o.
- **Merge:** two add_i pulses arrive while busy_o=1 from a ripple → lost_o pulses once, and only one +2 is applied after the current operation finishes.
- **Clear mid-ripple:** clear_i asserted during D2 of 09:59+1 → 00:00, FSM in IDLE, no done_o, pending flags 0.
